// File: rtl/rsc_viterbi_decoder.sv
// Hard-decision Viterbi decoder for the 8-state RSC constituent code (K data + 3 tail steps).
// Define RSC_VITERBI_ERR_COUNT_EN to add err_cnt: data steps whose received sys differs from the decoded bit.
module rsc_viterbi_decoder #(
   parameter int BLOCK_LEN = 40,
   parameter int METRIC_W  = 8
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        sys,
   input  logic        par,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_bit,
   output logic        out_last,
`ifdef RSC_VITERBI_ERR_COUNT_EN
   output logic        busy,
   output logic [15:0] err_cnt
`else
   output logic        busy
`endif
);

   localparam int N  = BLOCK_LEN + 3;
   localparam int SW = $clog2(N);
   localparam logic [SW-1:0] LAST = SW'(N - 1);
   localparam logic [SW-1:0] K_S  = SW'(BLOCK_LEN);
   localparam logic [SW-1:0] K_M1 = SW'(BLOCK_LEN - 1);
   localparam logic [METRIC_W-1:0] MAX = '1;

   typedef enum logic [1:0] {RECV, TRACE, OUTPUT} state_e;

   state_e state_q, state_d;
   logic [SW-1:0] step_q, step_d, t_q, t_d, idx_q, idx_d;
   logic [2:0] ts_q, ts_d;
   logic [METRIC_W-1:0] pm_q [8];
   logic [METRIC_W-1:0] pm_d [8];
   logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic out_bit_q, out_bit_d, out_last_q, out_last_d, busy_q, busy_d;

   logic [7:0] surv_q [N];
   logic [BLOCK_LEN-1:0] buf_q;

   logic [1:0] bm0 [8];
   logic [1:0] bm1 [8];
   logic [METRIC_W-1:0] c0 [8];
   logic [METRIC_W-1:0] c1 [8];
   logic [METRIC_W-1:0] acs [8];
   logic [METRIC_W-1:0] pm_n [8];
   logic [METRIC_W-1:0] mn;
   logic [7:0] dec;
   logic tail, accept, trace_go, surv_we, buf_we, d_tr, bit_tr;
   logic [SW-1:0] idx_nx;

   function automatic logic [METRIC_W-1:0] sat_add(
      input logic [METRIC_W-1:0] a,
      input logic [1:0]          b
   );
      logic [METRIC_W:0] s;
      s = {1'b0, a} + {{(METRIC_W-1){1'b0}}, b};
      return s[METRIC_W] ? MAX : s[METRIC_W-1:0];
   endfunction

   assign accept   = in_valid & in_ready_q;
   assign tail     = (step_q >= K_S);
   assign trace_go = accept && (step_q == LAST);
   assign surv_we  = accept;
   assign buf_we   = (state_q == TRACE) && (t_q < K_S);
   assign d_tr     = surv_q[t_q][ts_q];
   assign bit_tr   = ts_q[2] ^ ts_q[0] ^ d_tr;
   assign idx_nx   = idx_q + SW'(1);

   // Predecessor of n via decision d is {n[1],n[0],d}
   always_comb begin
      for (int n = 0; n < 8; n++) begin
         bm0[n] = {1'b0, sys ^ n[2] ^ n[0]} + {1'b0, par ^ n[2] ^ n[1]};
         bm1[n] = {1'b0, sys ^ n[2] ^ n[0] ^ 1'b1} +
                  {1'b0, par ^ n[2] ^ n[1] ^ 1'b1};
         c0[n]  = sat_add(pm_q[{n[1], n[0], 1'b0}], bm0[n]);
         c1[n]  = sat_add(pm_q[{n[1], n[0], 1'b1}], bm1[n]);
         dec[n] = (c1[n] < c0[n]);
         acs[n] = dec[n] ? c1[n] : c0[n];
         if (tail && n[2]) acs[n] = MAX;
      end
      mn = acs[0];
      for (int n = 1; n < 8; n++)
         if (acs[n] < mn) mn = acs[n];
      for (int n = 0; n < 8; n++)
         pm_n[n] = (acs[n] == MAX) ? MAX : acs[n] - mn;
   end

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      t_d         = t_q;
      ts_d        = ts_q;
      idx_d       = idx_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_bit_d   = out_bit_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      for (int n = 0; n < 8; n++) pm_d[n] = pm_q[n];
      unique case (state_q)
         RECV: begin
            if (accept) begin
               for (int n = 0; n < 8; n++) pm_d[n] = pm_n[n];
               busy_d = 1'b1;
               if (trace_go) begin
                  state_d    = TRACE;
                  in_ready_d = 1'b0;
                  step_d     = '0;
                  t_d        = LAST;
                  ts_d       = 3'd0;
               end else begin
                  step_d = step_q + SW'(1);
               end
            end
         end
         TRACE: begin
            ts_d = {ts_q[1:0], d_tr};
            if (t_q == '0) begin
               state_d     = OUTPUT;
               out_valid_d = 1'b1;
               out_bit_d   = bit_tr;
               out_last_d  = (BLOCK_LEN == 1);
               idx_d       = '0;
            end else begin
               t_d = t_q - SW'(1);
            end
         end
         OUTPUT: begin
            if (out_ready) begin
               if (idx_q == K_M1) begin
                  state_d     = RECV;
                  out_valid_d = 1'b0;
                  out_bit_d   = 1'b0;
                  out_last_d  = 1'b0;
                  busy_d      = 1'b0;
                  in_ready_d  = 1'b1;
                  idx_d       = '0;
                  for (int n = 0; n < 8; n++) pm_d[n] = (n == 0) ? '0 : MAX;
               end else begin
                  idx_d      = idx_nx;
                  out_bit_d  = buf_q[idx_nx];
                  out_last_d = (idx_nx == K_M1);
               end
            end
         end
         default: state_d = RECV;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= RECV;
         step_q      <= '0;
         t_q         <= '0;
         ts_q        <= 3'd0;
         idx_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         for (int n = 0; n < 8; n++) pm_q[n] <= (n == 0) ? '0 : MAX;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         t_q         <= t_d;
         ts_q        <= ts_d;
         idx_q       <= idx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         for (int n = 0; n < 8; n++) pm_q[n] <= pm_d[n];
      end
   end

   // Survivor and decoded-bit storage need no reset
   always_ff @(posedge clk) begin
      if (surv_we) surv_q[step_q] <= dec;
      if (buf_we) buf_q[t_q] <= bit_tr;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_bit   = out_bit_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

`ifdef RSC_VITERBI_ERR_COUNT_EN
   logic [BLOCK_LEN-1:0] sysb_q;
   logic [15:0] err_run_q, err_run_d, err_cnt_q, err_cnt_d;
   logic mis;

   always_comb begin
      mis       = buf_we && (sysb_q[t_q] != bit_tr);
      err_run_d = err_run_q;
      err_cnt_d = err_cnt_q;
      if (trace_go) err_run_d = '0;
      else if (mis) err_run_d = err_run_q + 16'd1;
      if (state_q == TRACE && t_q == '0) err_cnt_d = err_run_d;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         err_run_q <= '0;
         err_cnt_q <= '0;
      end else begin
         err_run_q <= err_run_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (surv_we && step_q < K_S) sysb_q[step_q] <= sys;
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_rsc_viterbi_decoder.sv
// Scoreboard bench for rsc_viterbi_decoder: encoder model feeds blocks,
// expected information bits are queued and checked by an independent monitor.
module tb_rsc_viterbi_decoder;

   localparam int K = 40;

   logic clk = 1'b0;
   logic clr, in_valid, sys, par, out_ready;
   logic in_ready, out_valid, out_bit, out_last, busy;
`ifdef RSC_VITERBI_ERR_COUNT_EN
   logic [15:0] err_cnt;
`endif

   rsc_viterbi_decoder #(.BLOCK_LEN(K), .METRIC_W(8)) dut (
      .clk(clk),
      .clr(clr),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .sys(sys),
      .par(par),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_bit(out_bit),
      .out_last(out_last),
`ifdef RSC_VITERBI_ERR_COUNT_EN
      .busy(busy),
      .err_cnt(err_cnt)
`else
      .busy(busy)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input bit ok,
                        input longint act, input longint exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   typedef struct {
      logic b;
      logic last;
   } exp_t;

   exp_t exp_q[$];
   int   err_q[$];
   int   acc_cyc = 0;
   int   blk_bits = 0;
   bit   stall_pend = 0;
   bit   rnd_rdy = 0;
   bit   chk_ir = 0;
   logic prev_ov = 0, prev_rdy = 1, prev_bit = 0, prev_last = 0;

   // Monitor: samples mid-cycle, handshake completes at the next rising edge
   always @(negedge clk) begin
      exp_t e;
      int   ee;
      if (chk_ir) begin
         chk_ir = 0;
         check("in_ready_after_block", in_ready && !busy,
               {in_ready, busy}, 2'b10);
      end
      if (out_valid) begin
         if (!prev_ov) begin
            check("latency", (cyc - acc_cyc - 1) == K + 3,
                  cyc - acc_cyc - 1, K + 3);
`ifdef RSC_VITERBI_ERR_COUNT_EN
            if (err_q.size() == 0) check("err_cnt_unexpected", 0, err_cnt, 0);
            else begin
               ee = err_q.pop_front();
               check("err_cnt", err_cnt == ee, err_cnt, ee);
            end
`endif
         end else if (!prev_rdy) begin
            check("stall_stable", out_bit == prev_bit && out_last == prev_last,
                  {out_bit, out_last}, {prev_bit, prev_last});
         end
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_bit", 0, out_bit, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_bit", out_bit == e.b, out_bit, e.b);
               check("out_last", out_last == e.last, out_last, e.last);
               blk_bits++;
               if (e.last) begin
                  blk_bits = 0;
                  chk_ir = 1;
               end
            end
         end
      end else if (prev_ov) begin
         check("valid_drop_at_end", blk_bits == 0, blk_bits, 0);
      end
      prev_ov   = out_valid;
      prev_rdy  = out_ready;
      prev_bit  = out_bit;
      prev_last = out_last;
   end

   // Downstream ready: optional 5-cycle stall at bit 7, or random backpressure
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_pend && blk_bits == 7) begin
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
            stall_pend = 0;
         end else if (rnd_rdy) begin
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // gaps: 0 none, 1 idle cycle between every step, 2 random idles
   task automatic send_block(input logic [K-1:0] u, input int fs, input int fp,
                             input int gaps, input int abort_at);
      logic s_v [K+3];
      logic p_v [K+3];
      logic [2:0] q;
      logic f, d2, ok;
      int nerr;
      q = 3'd0;
      nerr = 0;
      for (int i = 0; i < K + 3; i++) begin
         f = q[1] ^ q[0];
         if (i < K) begin
            d2 = u[i] ^ f;
            s_v[i] = u[i];
            p_v[i] = d2 ^ q[2] ^ q[0];
            q = {d2, q[2], q[1]};
         end else begin
            s_v[i] = f;
            p_v[i] = q[2] ^ q[0];
            q = {1'b0, q[2], q[1]};
         end
      end
      if (fs >= 0) begin
         s_v[fs] = ~s_v[fs];
         if (fs < K) nerr++;
      end
      if (fp >= 0) p_v[fp] = ~p_v[fp];
      if (abort_at < 0) begin
         for (int i = 0; i < K; i++) exp_q.push_back('{b: u[i], last: (i == K - 1)});
         err_q.push_back(nerr);
      end
      for (int i = 0; i < K + 3; i++) begin
         if (i == abort_at) begin
            in_valid = 1'b0;
            clr = 1'b1;
            @(posedge clk);
            #1;
            clr = 1'b0;
            @(negedge clk);
            check("clr_busy", busy == 1'b0, busy, 0);
            check("clr_in_ready", in_ready == 1'b1, in_ready, 1);
            check("clr_out_valid", out_valid == 1'b0, out_valid, 0);
            @(posedge clk);
            #1;
            return;
         end
         if ((gaps == 1 && i > 0) || (gaps == 2 && $urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         sys = s_v[i];
         par = p_v[i];
         ok = 1'b0;
         for (int w = 0; w < 1000 && !ok; w++) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) acc_cyc = cyc;
            @(posedge clk);
            #1;
         end
         if (!ok) check("in_ready_timeout", 0, 0, 1);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 4000) begin
         @(posedge clk);
         w++;
      end
      check("drain", exp_q.size() == 0, exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [K-1:0] zeros, a5, ru;
      logic [63:0]  r;
      int sel, fs, fp;
      zeros = '0;
      a5 = 40'hA5A5A5A5A5;
      clr = 1'b1;
      in_valid = 1'b0;
      sys = 1'b0;
      par = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      clr = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready == 1'b1, in_ready, 1);
      check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
      check("rst_out_bit", out_bit == 1'b0, out_bit, 0);
      check("rst_out_last", out_last == 1'b0, out_last, 0);
      check("rst_busy", busy == 1'b0, busy, 0);
      @(posedge clk);
      #1;

      send_block(zeros, -1, -1, 0, -1);
      drain();
      send_block(a5, -1, -1, 0, -1);
      drain();
      send_block(a5, 25, 10, 0, -1);
      drain();
      stall_pend = 1;
      send_block(a5, -1, -1, 1, -1);
      drain();
      send_block(a5, -1, -1, 0, 20);
      send_block(zeros, -1, -1, 0, -1);
      drain();
      send_block(zeros, -1, -1, 0, -1);
      send_block(a5, -1, -1, 0, -1);
      drain();

      rnd_rdy = 1;
      for (int b = 0; b < 6; b++) begin
         r = {$urandom(), $urandom()};
         ru = r[K-1:0];
         sel = $urandom_range(0, 2);
         fs = (sel == 1) ? int'($urandom_range(0, K + 2)) : -1;
         fp = (sel == 2) ? int'($urandom_range(0, K + 2)) : -1;
         send_block(ru, fs, fp, 2, -1);
      end
      drain();
      rnd_rdy = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rsc_viterbi_decoder.md
Name: rsc_viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the 8-state recursive systematic convolutional constituent code produced by the team's turbo constituent encoder.
- Consumes one (systematic, parity) bit pair per trellis step for one terminated block: BLOCK_LEN data steps plus 3 tail steps.
- Recovers the BLOCK_LEN information bits and streams them out in order.
- Used as the loopback/checker end of the encoder datapath and as the baseline decoder before the soft-input turbo decoder.

Parameters:
BLOCK_LEN, 40, information bits per block (K); tail is always 3 extra steps
METRIC_W, 8, path-metric width in bits; metrics saturate at 2^METRIC_W-1

Ports:
clk  input  1  clock, all logic on rising edge
clr  input  1  synchronous active-high reset
in_valid  input  1  sys/par carry a valid trellis step
in_ready  output  1  decoder accepts a step this cycle
sys  input  1  received systematic bit
par  input  1  received parity bit
out_valid  output  1  out_bit valid
out_ready  input  1  downstream accepts out_bit
out_bit  output  1  decoded information bit, block order bit 0 first
out_last  output  1  high with the final (index K-1) bit
busy  output  1  high from first accepted step until last bit accepted

Behaviour:
- Code definition:
  - State s={Q2,Q1,Q0}. Data step with input u: f=Q1^Q0, D2=u^f, sys=u, par=D2^Q2^Q0, next={D2,Q2,Q1}.
  - Tail step: D2=0, sys=f, par=Q2^Q0.
  - Encoder starts and ends in state 0.
- Trellis:
  - Next state n has predecessors p={n[1],n[0],d}, d in {0,1}.
  - Expected sys=n[2]^p[1]^p[0]; expected par=n[2]^p[2]^p[0].
  - Branch metric = Hamming distance of (sys,par) to expected, 0..2.
- ACS:
  - One step per accepted symbol; candidate = pm[p]+bm, saturating.
  - Smaller candidate wins. Tie selects d=0. Decision bit d stored in survivor RAM[step][n].
  - During the 3 tail steps, states with n[2]=1 are forced to saturated max.
- Normalisation: after each ACS, subtract the minimum new metric from all 8 metrics; saturated values stay saturated.
- Reset / block start metrics: pm[0]=0, all others saturated.
- FSM:
  - RECV: in_ready=1; each in_valid&in_ready performs ACS and increments step 0..K+2. After step K+2, go to TRACE; in_ready drops the following cycle.
  - TRACE: start at state 0. For t=K+2 down to 0, one t per cycle (K+3 cycles):
    - d=RAM[t][state]; prev={state[1:0],d}
    - if t<K, buf[t]=state[2]^prev[1]^prev[0]
    - state=prev
  - OUTPUT: out_valid=1 with out_bit=buf[idx]. idx advances only when out_valid&out_ready; out_last when idx=K-1. After the last accept, metrics are re-initialised and the FSM returns to RECV.
- Latency: the first out_valid rises K+3 cycles after the cycle in which the final tail symbol is accepted.
- Boundary cases:
  - in_valid gaps in RECV are allowed; the trellis does not advance.
  - in_valid during TRACE/OUTPUT is ignored (in_ready=0).
  - out_ready low holds out_bit/out_last stable.
- Reset values: in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0, FSM=RECV, step=0, idx=0, metrics at start values.
- clr asserted at any point (mid-RECV, TRACE or OUTPUT) aborts the block and restores reset values next cycle. No partial output is emitted afterwards.

Optional Feature:
- Macro RSC_VITERBI_ERR_COUNT_EN.
- Defined:
  - Adds output err_cnt, 16 bits: count of data steps where received sys differs from the decoded bit.
  - Computed during TRACE by keeping received sys bits in a K-bit register.
  - Valid from the first out_valid; held until the next block's first out_valid; reset to 0.
- Undefined: no port, no sys storage, no counter logic.

Test Plan:
- All-zero block, K=40: 43 steps of (0,0) -> 40 bits all 0, out_last on bit 39, err_cnt=0.
- Encoder-generated block for u=0xA5 repeated (40 bits) plus tail, fed error-free -> out matches u exactly; first out_valid exactly 43 cycles after last tail accept.
- Same block with the parity bit flipped at step 10 and the sys bit flipped at step 25 -> exact u recovered; err_cnt=1.
- in_valid toggled 1-0-1 every cycle and out_ready low for 5 cycles at bit 7 -> identical output; out_bit stable while stalled; out_valid never drops mid-block.
- clr pulsed at step 20, then a fresh all-zero block -> no stale bits; output all 0; busy low the cycle after clr.
- Two back-to-back blocks (zeros then 0xA5 pattern) -> second block decodes correctly; metrics re-initialised; in_ready returns high the cycle after the last output accept.
